// File: rtl/step_ramp_ctrl.sv
// Trapezoidal speed-profile sequencer driving a frq_divider; profile advances once per rising step edge,
// period updates are registered on the edge that samples the step; no backpressure, start ignored while busy.
module step_ramp_ctrl #(
    parameter int PERIOD_W = 35,
    parameter int STEP_W   = 24
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                dir_in,
    input  logic [STEP_W-1:0]   target_steps,
    input  logic [PERIOD_W-1:0] max_period,
    input  logic [PERIOD_W-1:0] min_period,
    input  logic [PERIOD_W-1:0] accel_inc,
    input  logic                step_in,
    output logic [PERIOD_W-1:0] time_to_count,
    output logic                div_rst_n,
    output logic                dir_out,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [STEP_W-1:0]   step_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEL  = 3'd1,
        S_CRUISE = 3'd2,
        S_DECEL  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              state;
    logic                step_in_d;
    logic [STEP_W-1:0]   target_r;
    logic [STEP_W-1:0]   acc_cnt;
    logic [PERIOD_W-1:0] max_r;
    logic [PERIOD_W-1:0] min_r;
    logic [PERIOD_W-1:0] inc_r;

    logic                step_rise;
    logic [STEP_W-1:0]   cnt_nxt;
    logic [STEP_W-1:0]   rem;
    logic                rem_zero;
    logic                rem_le_acc;
    logic                dn_floor;
    logic [PERIOD_W:0]   up_sum;
    logic [PERIOD_W-1:0] per_up;
    logic [PERIOD_W-1:0] per_dn;
    logic [STEP_W-1:0]   abort_tgt;

    assign step_rise  = step_in & ~step_in_d;
    assign cnt_nxt    = step_count + STEP_W'(1);
    assign rem        = target_r - cnt_nxt;
    assign rem_zero   = (rem == '0);
    assign rem_le_acc = (rem <= acc_cnt);

    // Compare/sum one bit wider so a large accel_inc can neither underflow nor wrap.
    assign dn_floor = ({1'b0, time_to_count} <= ({1'b0, min_r} + {1'b0, inc_r}));
    assign up_sum   = {1'b0, time_to_count} + {1'b0, inc_r};
    assign per_up   = (up_sum >= {1'b0, max_r}) ? max_r : up_sum[PERIOD_W-1:0];
    assign per_dn   = time_to_count - inc_r;

    // acc_cnt+1 decel steps walk the period back up to max_r before stopping.
    assign abort_tgt = (step_rise ? cnt_nxt : step_count) + acc_cnt + STEP_W'(1);

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            step_in_d     <= 1'b0;
            target_r      <= '0;
            acc_cnt       <= '0;
            max_r         <= '0;
            min_r         <= '0;
            inc_r         <= '0;
            time_to_count <= '0;
            div_rst_n     <= 1'b0;
            dir_out       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            step_count    <= '0;
        end else begin
            step_in_d <= step_in;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        target_r   <= target_steps;
                        max_r      <= max_period;
                        min_r      <= (min_period > max_period) ? max_period : min_period;
                        inc_r      <= accel_inc;
                        dir_out    <= dir_in;
                        step_count <= '0;
                        acc_cnt    <= '0;
                        aborted    <= 1'b0;
                        busy       <= 1'b1;
                        if (target_steps == '0) begin
                            state <= S_DONE;
                        end else begin
                            time_to_count <= max_period;
                            div_rst_n     <= 1'b1;
                            state         <= S_ACCEL;
                        end
                    end
                end
                S_ACCEL, S_CRUISE: begin
                    if (step_rise)
                        step_count <= cnt_nxt;
                    if (abort)
                        aborted <= 1'b1;
                    if (step_rise && rem_zero) begin
                        state <= S_DONE;
                    end else if (abort) begin
                        target_r <= abort_tgt;
                        state    <= S_DECEL;
                    end else if (step_rise) begin
                        if (rem_le_acc) begin
                            time_to_count <= per_up;
                            state         <= S_DECEL;
                        end else if (state == S_ACCEL) begin
                            if (dn_floor) begin
                                time_to_count <= min_r;
                                state         <= S_CRUISE;
                            end else begin
                                time_to_count <= per_dn;
                                acc_cnt       <= acc_cnt + STEP_W'(1);
                            end
                        end
                    end
                end
                S_DECEL: begin
                    if (abort)
                        aborted <= 1'b1;
                    if (step_rise) begin
                        step_count    <= cnt_nxt;
                        time_to_count <= per_up;
                        if (rem_zero)
                            state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done      <= 1'b1;
                    div_rst_n <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_step_ramp_ctrl.sv
// Bench for step_ramp_ctrl: table of move vectors plus hand sequences for zero-length, reset and busy/done corner cases.
module tb_step_ramp_ctrl;

    localparam int PW = 35;
    localparam int SW = 24;

    logic          clk_in = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          dir_in;
    logic [SW-1:0] target_steps;
    logic [PW-1:0] max_period;
    logic [PW-1:0] min_period;
    logic [PW-1:0] accel_inc;
    logic          step_in;
    logic [PW-1:0] time_to_count;
    logic          div_rst_n;
    logic          dir_out;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [SW-1:0] step_count;

    step_ramp_ctrl #(.PERIOD_W(PW), .STEP_W(SW)) dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .dir_in        (dir_in),
        .target_steps  (target_steps),
        .max_period    (max_period),
        .min_period    (min_period),
        .accel_inc     (accel_inc),
        .step_in       (step_in),
        .time_to_count (time_to_count),
        .div_rst_n     (div_rst_n),
        .dir_out       (dir_out),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .step_count    (step_count)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [SW-1:0] target;
        logic [PW-1:0] maxp;
        logic [PW-1:0] minp;
        logic [PW-1:0] inc;
        int            abort_at;
        int            per_off;
        int            nper;
        logic [SW-1:0] exp_count;
        logic          exp_aborted;
        logic [PW-1:0] exp_period;
    } vec_t;

    typedef struct {
        logic [PW-1:0] per;
        logic          chk_per;
        logic [SW-1:0] cnt;
    } exp_t;

    vec_t vt[8];
    int   per_tab[17];
    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [SW-1:0] t, input logic [PW-1:0] mx, input logic [PW-1:0] mn,
                            input logic [PW-1:0] inc, input logic d);
        @(negedge clk_in);
        target_steps = t;
        max_period   = mx;
        min_period   = mn;
        accel_inc    = inc;
        dir_in       = d;
        start        = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
    endtask

    // One step pulse; expected result queued when driven, checked once the DUT has sampled it.
    task automatic pulse(input exp_t e);
        exp_t got;
        @(negedge clk_in);
        step_in = 1'b1;
        sb_q.push_back(e);
        @(negedge clk_in);
        step_in = 1'b0;
        got = sb_q.pop_front();
        chk("step_count", 64'(step_count), 64'(got.cnt));
        chk("busy_in_move", 64'(busy), 64'd1);
        if (got.chk_per)
            chk("period", 64'(time_to_count), 64'(got.per));
    endtask

    task automatic wait_done(output logic seen);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_in);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
    endtask

    task automatic run_vec(input int vi, input logic d);
        vec_t v;
        exp_t e;
        logic seen;
        v = vt[vi];
        do_start(v.target, v.maxp, v.minp, v.inc, d);
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_div_rst_n", 64'(div_rst_n), 64'd1);
        chk("start_period", 64'(time_to_count), 64'(v.maxp));
        chk("start_dir", 64'(dir_out), 64'(d));
        chk("start_aborted", 64'(aborted), 64'd0);
        for (int i = 1; i <= int'(v.exp_count); i++) begin
            e.cnt     = SW'(i);
            e.chk_per = (i <= v.nper);
            e.per     = (i <= v.nper) ? PW'(per_tab[v.per_off + i - 1]) : '0;
            pulse(e);
            if (i == v.abort_at) begin
                @(negedge clk_in);
                abort = 1'b1;
                @(negedge clk_in);
                abort = 1'b0;
            end
        end
        wait_done(seen);
        chk("end_count", 64'(step_count), 64'(v.exp_count));
        chk("end_aborted", 64'(aborted), 64'(v.exp_aborted));
        chk("end_period", 64'(time_to_count), 64'(v.exp_period));
        chk("end_div_rst_n", 64'(div_rst_n), 64'd0);
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_dir", 64'(dir_out), 64'(d));
        @(negedge clk_in);
        chk("done_one_cycle", 64'(done), 64'd0);
    endtask

    initial begin
        logic seen;
        exp_t e;
        per_tab = '{80, 60, 40, 40, 40, 40, 40, 60, 80, 100,
                    80, 100, 100,
                    100, 100, 100, 100};
        //          target  max  min  inc  abort off  n  count  ab  final
        vt[0] = '{24'd10,   35'd100, 35'd40,  35'd20, 0,  0,  10, 24'd10, 1'b0, 35'd100};
        vt[1] = '{24'd3,    35'd100, 35'd10,  35'd20, 0,  10, 3,  24'd3,  1'b0, 35'd100};
        vt[2] = '{24'd1000, 35'd100, 35'd40,  35'd20, 50, 0,  0,  24'd53, 1'b1, 35'd100};
        vt[3] = '{24'd4,    35'd100, 35'd200, 35'd20, 0,  13, 4,  24'd4,  1'b0, 35'd100};
        vt[4] = '{24'd1,    35'd50,  35'd10,  35'd5,  0,  0,  0,  24'd1,  1'b0, 35'd50};
        vt[5] = '{24'd100,  35'd100, 35'd40,  35'd20, 1,  0,  0,  24'd3,  1'b1, 35'd100};
        vt[6] = '{24'd5,    35'd30,  35'd10,  35'd50, 0,  0,  0,  24'd5,  1'b0, 35'd10};
        vt[7] = '{24'd20,   35'd30,  35'd10,  35'd50, 2,  0,  0,  24'd3,  1'b1, 35'd30};

        rst = 1'b0; start = 1'b0; abort = 1'b0; dir_in = 1'b0; step_in = 1'b0;
        target_steps = '0; max_period = '0; min_period = '0; accel_inc = '0;
        #12;
        chk("rst_period", 64'(time_to_count), 64'd0);
        chk("rst_div_rst_n", 64'(div_rst_n), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_count", 64'(step_count), 64'd0);
        @(negedge clk_in);
        rst = 1'b1;

        for (int vi = 0; vi < 8; vi++)
            run_vec(vi, 1'(vi));

        // Zero-length move: done two cycles after start, divider never released.
        do_start(24'd0, 35'd100, 35'd40, 35'd20, 1'b1);
        chk("t0_busy", 64'(busy), 64'd1);
        chk("t0_div_rst_n", 64'(div_rst_n), 64'd0);
        chk("t0_done_early", 64'(done), 64'd0);
        @(negedge clk_in);
        chk("t0_done", 64'(done), 64'd1);
        chk("t0_busy_clr", 64'(busy), 64'd0);
        chk("t0_div_rst_n_end", 64'(div_rst_n), 64'd0);
        @(negedge clk_in);
        chk("t0_done_clr", 64'(done), 64'd0);

        // Start while busy and start in DONE are both ignored.
        do_start(24'd4, 35'd100, 35'd200, 35'd20, 1'b0);
        e = '{35'd100, 1'b1, 24'd1};
        pulse(e);
        @(negedge clk_in);
        target_steps = 24'd1; max_period = 35'd500; dir_in = 1'b1; start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        chk("busy_start_period", 64'(time_to_count), 64'd100);
        chk("busy_start_count", 64'(step_count), 64'd1);
        chk("busy_start_dir", 64'(dir_out), 64'd0);
        e = '{35'd100, 1'b1, 24'd2};
        pulse(e);
        e = '{35'd100, 1'b1, 24'd3};
        pulse(e);
        @(negedge clk_in);
        step_in = 1'b1;
        @(negedge clk_in);
        step_in = 1'b0;
        start   = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        chk("done_start_done", 64'(done), 64'd1);
        chk("done_start_count", 64'(step_count), 64'd4);
        @(negedge clk_in);
        chk("done_start_busy", 64'(busy), 64'd0);
        chk("done_start_div", 64'(div_rst_n), 64'd0);

        // Async reset mid-cruise clears outputs without waiting for a clock edge.
        do_start(24'd10, 35'd100, 35'd40, 35'd20, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            e = '{per_tab[i - 1], 1'b1, SW'(i)};
            pulse(e);
        end
        @(posedge clk_in);
        #2 rst = 1'b0;
        #1;
        chk("arst_period", 64'(time_to_count), 64'd0);
        chk("arst_div_rst_n", 64'(div_rst_n), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_count", 64'(step_count), 64'd0);
        chk("arst_dir", 64'(dir_out), 64'd0);
        @(negedge clk_in);
        rst = 1'b1;
        run_vec(0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
